// File: rtl/var_sqrt_pkg.sv
// Shared constants, derived widths and the saturating shift used by the variance-to-address path.
`default_nettype none

package var_sqrt_pkg;

  localparam int W_SUM    = 18;
  localparam int W_SQSUM  = 26;
  localparam int WIN_AREA = 576;
  localparam int W_AREA   = 10;
  localparam int W_ADDR   = 8;
  localparam int SHIFT    = 27;

  localparam int W_PSQ  = 2 * W_SUM;
  localparam int W_PN   = W_SQSUM + W_AREA;
  localparam int W_DIFF = ((W_PSQ > W_PN) ? W_PSQ : W_PN) + 1;

  // Operates on a 64-bit container so any parameterisation with W_DIFF <= 64 can share it.
  function automatic logic [63:0] sat_shift(input logic [63:0] d, input int shift, input int w_addr);
    logic [63:0] v;
    logic [63:0] lim;
    v   = d >> shift;
    lim = (64'd1 << w_addr) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/var_sqrt_addr_if.sv
// Operand-in / ROM-address-out handshake bundle for var_sqrt_addr.
`default_nettype none

interface var_sqrt_addr_if #(
  parameter int W_SUM   = var_sqrt_pkg::W_SUM,
  parameter int W_SQSUM = var_sqrt_pkg::W_SQSUM,
  parameter int W_ADDR  = var_sqrt_pkg::W_ADDR
);

  logic               in_valid;
  logic               in_ready;
  logic [W_SUM-1:0]   in_sum;
  logic [W_SQSUM-1:0] in_sqsum;
  logic               addr_valid;
  logic               addr_ready;
  logic [W_ADDR-1:0]  addr_data;

  modport master (
    output in_valid, in_sum, in_sqsum, addr_ready,
    input  in_ready, addr_valid, addr_data
  );

  modport slave (
    input  in_valid, in_sum, in_sqsum, addr_ready,
    output in_ready, addr_valid, addr_data
  );

endinterface

`default_nettype wire

// File: rtl/var_sqrt_addr_pipe_stage.sv
// Generic W-bit valid/ready register slice; loads whenever empty or the downstream advances.
`default_nettype none

module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         valid,
  input  logic         down_ready,
  output logic [W-1:0] data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         ld;

  always_comb begin
    ld      = !valid_q || down_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (ld) begin
      valid_d = up_valid;
      // Data only captured on a real transfer so a held slot never picks up idle bus values.
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign up_ready = ld;
  assign valid    = valid_q;
  assign data     = data_q;

endmodule

`default_nettype wire

// File: rtl/var_sqrt_addr.sv
// Window variance N*sqsum - sum^2, clamped, shifted and saturated into a sqrt ROM address (3 stages).
`default_nettype none

module var_sqrt_addr #(
  parameter int W_SUM    = var_sqrt_pkg::W_SUM,
  parameter int W_SQSUM  = var_sqrt_pkg::W_SQSUM,
  parameter int WIN_AREA = var_sqrt_pkg::WIN_AREA,
  parameter int W_AREA   = var_sqrt_pkg::W_AREA,
  parameter int W_ADDR   = var_sqrt_pkg::W_ADDR,
  parameter int SHIFT    = var_sqrt_pkg::SHIFT
) (
  input  logic           clk,
  input  logic           rst,
  var_sqrt_addr_if.slave bus
);

  import var_sqrt_pkg::*;

  localparam int W_PSQ  = 2 * W_SUM;
  localparam int W_PN   = W_SQSUM + W_AREA;
  localparam int W_DIFF = ((W_PSQ > W_PN) ? W_PSQ : W_PN) + 1;
  localparam int W_S1   = W_PSQ + W_PN;

  logic [W_PSQ-1:0]  p_sq;
  logic [W_PN-1:0]   p_n;
  logic [W_S1-1:0]   s1_data;
  logic              s1_valid;
  logic              s1_up_ready;
  logic [W_PSQ-1:0]  s1_psq;
  logic [W_PN-1:0]   s1_pn;

  logic [W_DIFF-1:0] diff;
  logic [W_DIFF-1:0] d_clamped;
  logic [W_DIFF-1:0] s2_data;
  logic              s2_valid;
  logic              s2_up_ready;

  logic [W_ADDR-1:0] addr_next;
  logic [W_ADDR-1:0] s3_data;
  logic              s3_valid;
  logic              s3_up_ready;

  always_comb begin
    p_sq = W_PSQ'(bus.in_sum) * W_PSQ'(bus.in_sum);
    p_n  = W_PN'(WIN_AREA) * W_PN'(bus.in_sqsum);
  end

  pipe_stage #(.W(W_S1)) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (bus.in_valid),
    .up_ready   (s1_up_ready),
    .up_data    ({p_sq, p_n}),
    .valid      (s1_valid),
    .down_ready (s2_up_ready),
    .data       (s1_data)
  );

  assign s1_psq = s1_data[W_S1-1 -: W_PSQ];
  assign s1_pn  = s1_data[W_PN-1:0];

  // Both products are zero-extended by one bit so the MSB of the difference is its sign.
  always_comb begin
    diff      = W_DIFF'(s1_pn) - W_DIFF'(s1_psq);
    d_clamped = diff[W_DIFF-1] ? '0 : diff;
  end

  pipe_stage #(.W(W_DIFF)) u_s2 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (s1_valid),
    .up_ready   (s2_up_ready),
    .up_data    (d_clamped),
    .valid      (s2_valid),
    .down_ready (s3_up_ready),
    .data       (s2_data)
  );

  always_comb begin
    addr_next = W_ADDR'(sat_shift(64'(s2_data), SHIFT, W_ADDR));
  end

  pipe_stage #(.W(W_ADDR)) u_s3 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (s2_valid),
    .up_ready   (s3_up_ready),
    .up_data    (addr_next),
    .valid      (s3_valid),
    .down_ready (bus.addr_ready),
    .data       (s3_data)
  );

  assign bus.in_ready   = s1_up_ready;
  assign bus.addr_valid = s3_valid;
  assign bus.addr_data  = s3_data;

endmodule

`default_nettype wire
